// File: rtl/rom_loader_pkg.sv
// Shared constants for the ROM download loader: bus widths, sync marker and FSM encodings.
package rom_loader_pkg;

    localparam int unsigned INST_ADDR_BUS = 32;
    localparam int unsigned INST_DATA_BUS = 32;
    localparam int unsigned ROM_NUM       = 4096;
    localparam logic [7:0]  LOADER_SYNC   = 8'hA5;
    localparam logic [INST_DATA_BUS-1:0] ZERO_WORD = '0;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LEN0  = 3'd1;
    localparam logic [2:0] ST_LEN1  = 3'd2;
    localparam logic [2:0] ST_ERASE = 3'd3;
    localparam logic [2:0] ST_DATA  = 3'd4;
    localparam logic [2:0] ST_CSUM  = 3'd5;
    localparam logic [2:0] ST_ERR   = 3'd6;

    // Word index to word-aligned byte address.
    function automatic logic [INST_ADDR_BUS-1:0] word_addr(input logic [15:0] idx);
        return {{(INST_ADDR_BUS-18){1'b0}}, idx, 2'b00};
    endfunction

endpackage

// File: rtl/rom_loader_if.sv
// Byte-stream input and ROM erase/write port of the loader, with loader (slave) and host (master) views.
interface rom_loader_if;
    import rom_loader_pkg::*;

    logic                     rx_valid_i;
    logic [7:0]               rx_data_i;
    logic                     erase_en_o;
    logic                     wr_en_o;
    logic [INST_ADDR_BUS-1:0] wr_addr_o;
    logic [INST_DATA_BUS-1:0] data_o;
    logic                     hold_o;
    logic                     done_o;
    logic                     err_o;

    modport slave (
        input  rx_valid_i, rx_data_i,
        output erase_en_o, wr_en_o, wr_addr_o, data_o, hold_o, done_o, err_o
    );

    modport master (
        output rx_valid_i, rx_data_i,
        input  erase_en_o, wr_en_o, wr_addr_o, data_o, hold_o, done_o, err_o
    );

endinterface

// File: rtl/rom_loader.sv
// Parses SYNC/LEN/data/CSUM download frames from the UART byte stream and drives the
// instruction ROM erase/write port, holding the core in reset while a download runs.
module rom_loader
    import rom_loader_pkg::*;
#(
    parameter int unsigned ROM_NUM        = rom_loader_pkg::ROM_NUM,
    parameter logic [7:0]  SYNC_BYTE      = LOADER_SYNC,
    parameter int unsigned TIMEOUT_CYCLES = 50_000_000
) (
    input  logic         clk,
    input  logic         rst_n,
    rom_loader_if.slave  bus
);

    localparam int unsigned     TMO_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TIMEOUT_CYCLES);
    localparam logic [16:0]     LEN_MAX = 17'(ROM_NUM);

    logic [2:0]               state_q, state_d;
    logic [15:0]              len_q, len_d;
    logic [15:0]              word_idx_q, word_idx_d;
    logic [1:0]               byte_cnt_q, byte_cnt_d;
    logic [31:0]              word_q, word_d;
    logic [7:0]               csum_q, csum_d;
    logic [TMO_W-1:0]         tmo_q, tmo_d;
    logic                     erase_en_q, erase_en_d;
    logic                     wr_en_q, wr_en_d;
    logic [INST_ADDR_BUS-1:0] wr_addr_q, wr_addr_d;
    logic [INST_DATA_BUS-1:0] data_q, data_d;
    logic                     hold_q, hold_d;
    logic                     done_q, done_d;
    logic                     err_q, err_d;

    logic rx_v;
    logic [7:0] rx_b;
    logic timed;
    logic take_data;
    logic take_csum;

    assign rx_v  = bus.rx_valid_i;
    assign rx_b  = bus.rx_data_i;
    assign timed = (state_q == ST_LEN0) || (state_q == ST_LEN1) ||
                   (state_q == ST_DATA) || (state_q == ST_CSUM);

    // The ERASE cycle already accepts the first payload byte; with LEN==0 that byte is the checksum.
    assign take_data = rx_v && ((state_q == ST_DATA) || ((state_q == ST_ERASE) && (len_q != 16'd0)));
    assign take_csum = rx_v && ((state_q == ST_CSUM) || ((state_q == ST_ERASE) && (len_q == 16'd0)));

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        word_idx_d = word_idx_q;
        byte_cnt_d = byte_cnt_q;
        word_d     = word_q;
        csum_d     = csum_q;
        tmo_d      = '0;
        erase_en_d = 1'b0;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        data_d     = data_q;
        hold_d     = hold_q;
        done_d     = 1'b0;
        err_d      = err_q;

        if (timed) begin
            tmo_d = rx_v ? '0 : tmo_q + TMO_W'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (rx_v && (rx_b == SYNC_BYTE)) begin
                    state_d    = ST_LEN0;
                    err_d      = 1'b0;
                    hold_d     = 1'b1;
                    len_d      = '0;
                    word_idx_d = '0;
                    byte_cnt_d = '0;
                    csum_d     = '0;
                end
            end
            ST_LEN0: begin
                if (rx_v) begin
                    len_d[7:0] = rx_b;
                    state_d    = ST_LEN1;
                end
            end
            ST_LEN1: begin
                if (rx_v) begin
                    len_d[15:8] = rx_b;
                    if ({1'b0, rx_b, len_q[7:0]} > LEN_MAX) begin
                        state_d = ST_ERR;
                        err_d   = 1'b1;
                    end else begin
                        state_d    = ST_ERASE;
                        erase_en_d = 1'b1;
                    end
                end
            end
            ST_ERASE: begin
                state_d = (len_q == 16'd0) ? ST_CSUM : ST_DATA;
            end
            ST_DATA, ST_CSUM: begin
            end
            ST_ERR: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (take_data) begin
            csum_d                       = csum_q + rx_b;
            word_d[{byte_cnt_q, 3'b000} +: 8] = rx_b;
            byte_cnt_d                   = byte_cnt_q + 2'd1;
            if (byte_cnt_q == 2'd3) begin
                wr_en_d    = 1'b1;
                wr_addr_d  = word_addr(word_idx_q);
                data_d     = {rx_b, word_q[23:0]};
                word_idx_d = word_idx_q + 16'd1;
                if ((word_idx_q + 16'd1) == len_q) begin
                    state_d = ST_CSUM;
                end
            end
        end

        if (take_csum) begin
            if (rx_b == csum_q) begin
                done_d  = 1'b1;
                hold_d  = 1'b0;
                state_d = ST_IDLE;
            end else begin
                err_d   = 1'b1;
                state_d = ST_ERR;
            end
        end

        if (timed && !rx_v && (tmo_q == TMO_MAX)) begin
            state_d = ST_ERR;
            err_d   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            len_q      <= '0;
            word_idx_q <= '0;
            byte_cnt_q <= '0;
            word_q     <= '0;
            csum_q     <= '0;
            tmo_q      <= '0;
            erase_en_q <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            data_q     <= ZERO_WORD;
            hold_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            word_idx_q <= word_idx_d;
            byte_cnt_q <= byte_cnt_d;
            word_q     <= word_d;
            csum_q     <= csum_d;
            tmo_q      <= tmo_d;
            erase_en_q <= erase_en_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            data_q     <= data_d;
            hold_q     <= hold_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign bus.erase_en_o = erase_en_q;
    assign bus.wr_en_o    = wr_en_q;
    assign bus.wr_addr_o  = wr_addr_q;
    assign bus.data_o     = data_q;
    assign bus.hold_o     = hold_q;
    assign bus.done_o     = done_q;
    assign bus.err_o      = err_q;

endmodule

// File: tb/tb_rom_loader.sv
// Directed bench for rom_loader: good frame, bad checksum, timeout, length limits, noise, reset, back-to-back bytes.
module tb_rom_loader;
    import rom_loader_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rom_loader_if bus ();

    rom_loader #(
        .ROM_NUM        (16),
        .SYNC_BYTE      (8'hA5),
        .TIMEOUT_CYCLES (100)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int unsigned total  = 0;
    int unsigned passed = 0;
    int erase_cnt   = 0;
    int done_cnt    = 0;
    int overlap_cnt = 0;
    logic [31:0] wa_q[$];
    logic [31:0] wd_q[$];

    always @(negedge clk) begin
        if (bus.erase_en_o) erase_cnt++;
        if (bus.done_o) done_cnt++;
        if (bus.erase_en_o && bus.wr_en_o) overlap_cnt++;
        if (bus.wr_en_o) begin
            wa_q.push_back(bus.wr_addr_o);
            wd_q.push_back(bus.data_o);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Returns 1 time unit after the edge that consumed the byte.
    task automatic send(input logic [7:0] b);
        bus.rx_valid_i = 1'b1;
        bus.rx_data_i  = b;
        @(posedge clk);
        #1;
        bus.rx_valid_i = 1'b0;
    endtask

    task automatic send_gap(input logic [7:0] b);
        idle(1);
        send(b);
    endtask

    task automatic send_b2b(input logic [7:0] bs[$]);
        foreach (bs[i]) begin
            bus.rx_valid_i = 1'b1;
            bus.rx_data_i  = bs[i];
            @(posedge clk);
            #1;
        end
        bus.rx_valid_i = 1'b0;
    endtask

    // Two-word frame 12345678 / DEADBEEF; data bytes sum to 0x44C, so the good checksum is 0x4C.
    task automatic frame_two_words(input logic [7:0] cs);
        send_gap(8'hA5); send_gap(8'h02); send_gap(8'h00);
        send_gap(8'h78); send_gap(8'h56); send_gap(8'h34); send_gap(8'h12);
        send_gap(8'hEF); send_gap(8'hBE); send_gap(8'hAD); send_gap(8'hDE);
        send_gap(cs);
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int e0;
        int d0;
        int w;
        logic [7:0] stream[$];

        bus.rx_valid_i = 1'b0;
        bus.rx_data_i  = 8'h00;
        rst_n = 1'b0;
        idle(2);
        check("rst_erase", 32'(bus.erase_en_o), 32'd0);
        check("rst_wr",    32'(bus.wr_en_o),    32'd0);
        check("rst_addr",  bus.wr_addr_o,       32'd0);
        check("rst_data",  bus.data_o,          32'd0);
        check("rst_hold",  32'(bus.hold_o),     32'd0);
        check("rst_done",  32'(bus.done_o),     32'd0);
        check("rst_err",   32'(bus.err_o),      32'd0);
        rst_n = 1'b1;
        idle(1);

        // Good two-word frame with per-step latency checks
        send(8'hA5);
        check("t1_hold_on", 32'(bus.hold_o), 32'd1);
        send_gap(8'h02);
        send_gap(8'h00);
        check("t1_erase", 32'(bus.erase_en_o), 32'd1);
        idle(1);
        check("t1_erase_1cyc", 32'(bus.erase_en_o), 32'd0);
        send_gap(8'h78); send_gap(8'h56); send_gap(8'h34);
        check("t1_no_wr_early", 32'(bus.wr_en_o), 32'd0);
        send_gap(8'h12);
        check("t1_wr0_en",   32'(bus.wr_en_o), 32'd1);
        check("t1_wr0_addr", bus.wr_addr_o, 32'h0000_0000);
        check("t1_wr0_data", bus.data_o,    32'h1234_5678);
        idle(1);
        check("t1_wr_1cyc", 32'(bus.wr_en_o), 32'd0);
        send(8'hEF); send_gap(8'hBE); send_gap(8'hAD); send_gap(8'hDE);
        check("t1_wr1_addr", bus.wr_addr_o, 32'h0000_0004);
        check("t1_wr1_data", bus.data_o,    32'hDEAD_BEEF);
        idle(3);
        check("t1_addr_held", bus.wr_addr_o, 32'h0000_0004);
        check("t1_data_held", bus.data_o,    32'hDEAD_BEEF);
        send(8'h4C);
        check("t1_done",     32'(bus.done_o), 32'd1);
        check("t1_hold_off", 32'(bus.hold_o), 32'd0);
        check("t1_err",      32'(bus.err_o),  32'd0);
        idle(1);
        check("t1_done_1cyc", 32'(bus.done_o), 32'd0);
        check("t1_erase_cnt", 32'(erase_cnt), 32'd1);
        check("t1_wr_cnt",    32'(wa_q.size()), 32'd2);
        check("t1_done_cnt",  32'(done_cnt), 32'd1);

        // Bad checksum: both words still written, error raised, core stays held
        wa_q.delete(); wd_q.delete();
        d0 = done_cnt;
        frame_two_words(8'h4D);
        check("t2_err",  32'(bus.err_o),  32'd1);
        check("t2_hold", 32'(bus.hold_o), 32'd1);
        idle(3);
        check("t2_err_sticky", 32'(bus.err_o), 32'd1);
        check("t2_hold_kept",  32'(bus.hold_o), 32'd1);
        check("t2_no_done",    32'(done_cnt), 32'(d0));
        check("t2_wr_cnt",     32'(wa_q.size()), 32'd2);
        check("t2_wr1_data",   wd_q[1], 32'hDEAD_BEEF);
        send_gap(8'hA5);
        check("t2_err_clear", 32'(bus.err_o), 32'd0);
        send_gap(8'h02); send_gap(8'h00);
        send_gap(8'h78); send_gap(8'h56); send_gap(8'h34); send_gap(8'h12);
        send_gap(8'hEF); send_gap(8'hBE); send_gap(8'hAD); send_gap(8'hDE);
        send_gap(8'h4C);
        check("t2_retry_done", 32'(bus.done_o), 32'd1);
        check("t2_retry_hold", 32'(bus.hold_o), 32'd0);

        // Timeout after a partial word
        idle(1);
        wa_q.delete(); wd_q.delete();
        send_gap(8'hA5); send_gap(8'h01); send_gap(8'h00); send_gap(8'h11); send_gap(8'h22);
        w = 0;
        while (!bus.err_o && w < 300) begin
            idle(1);
            w++;
        end
        check("t3_err",        32'(bus.err_o), 32'd1);
        check("t3_tmo_window", 32'(w >= 100 && w <= 102), 32'd1);
        check("t3_no_wr",      32'(wa_q.size()), 32'd0);
        check("t3_hold",       32'(bus.hold_o), 32'd1);

        // Oversized length rejected before erase
        e0 = erase_cnt;
        send_gap(8'hA5); send_gap(8'h11); send_gap(8'h00);
        check("t4_len_err",   32'(bus.err_o), 32'd1);
        check("t4_len_erase", 32'(bus.erase_en_o), 32'd0);
        idle(2);
        check("t4_erase_cnt", 32'(erase_cnt), 32'(e0));

        // Zero-length frame: erase only, then done
        send_gap(8'hA5);
        check("t4_err_clear", 32'(bus.err_o), 32'd0);
        send_gap(8'h00); send_gap(8'h00);
        check("t4_zero_erase", 32'(bus.erase_en_o), 32'd1);
        send_gap(8'h00);
        check("t4_zero_done", 32'(bus.done_o), 32'd1);
        check("t4_zero_hold", 32'(bus.hold_o), 32'd0);
        check("t4_zero_nowr", 32'(wa_q.size()), 32'd0);

        // Noise before sync is ignored
        idle(1);
        e0 = erase_cnt;
        d0 = done_cnt;
        send_gap(8'h00); send_gap(8'hFF); send_gap(8'h5A);
        idle(2);
        check("t5_noise_hold",  32'(bus.hold_o), 32'd0);
        check("t5_noise_err",   32'(bus.err_o), 32'd0);
        check("t5_noise_erase", 32'(erase_cnt), 32'(e0));
        check("t5_noise_done",  32'(done_cnt), 32'(d0));
        check("t5_noise_wr",    32'(wa_q.size()), 32'd0);

        // Reset mid-frame after six data bytes
        send_gap(8'hA5); send_gap(8'h03); send_gap(8'h00);
        send_gap(8'h01); send_gap(8'h02); send_gap(8'h03); send_gap(8'h04);
        send_gap(8'h05); send_gap(8'h06);
        check("t5_pre_rst_data", bus.data_o, 32'h0403_0201);
        idle(1);
        rst_n = 1'b0;
        #2;
        check("t5_rst_hold", 32'(bus.hold_o), 32'd0);
        check("t5_rst_data", bus.data_o, 32'd0);
        check("t5_rst_addr", bus.wr_addr_o, 32'd0);
        check("t5_rst_err",  32'(bus.err_o), 32'd0);
        idle(2);
        rst_n = 1'b1;
        idle(1);

        // Back-to-back bytes, first data byte lands in the erase cycle
        wa_q.delete(); wd_q.delete();
        e0 = erase_cnt;
        stream = '{8'hA5, 8'h02, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04,
                   8'h05, 8'h06, 8'h07, 8'h08, 8'h24};
        send_b2b(stream);
        check("t6_done", 32'(bus.done_o), 32'd1);
        check("t6_hold", 32'(bus.hold_o), 32'd0);
        idle(2);
        check("t6_wr_cnt",   32'(wa_q.size()), 32'd2);
        check("t6_wr0_addr", wa_q[0], 32'h0000_0000);
        check("t6_wr0_data", wd_q[0], 32'h0403_0201);
        check("t6_wr1_addr", wa_q[1], 32'h0000_0004);
        check("t6_wr1_data", wd_q[1], 32'h0807_0605);
        check("t6_erase_cnt", 32'(erase_cnt), 32'(e0 + 1));
        check("t6_overlap",   32'(overlap_cnt), 32'd0);
        check("t6_err",       32'(bus.err_o), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
